rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rom_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM port arbiter: requester count, default
// post-download hold length, FSM state type and a one-hot decode helper.
package rom_arb_pkg;

  localparam int NREQ         = 3;
  localparam int HOLD_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DL,
    POST
  } arb_state_e;

  // Index of the set bit in a one-hot requester grant (0 when empty).
  function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] g);
    logic [1:0] idx;
    idx = 2'd0;
    if (g[1]) idx = 2'd1;
    if (g[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick among three requesters: search starts at the requester
// following the last-granted one and wraps around. Purely combinational.
module rr_pick
  import rom_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] gnt
);

  // Priority order rotates with the last-granted index.
  always_comb begin
    gnt = '0;
    case (last)
      2'd0: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd1: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM port between three CPU requesters and the ROM
// download path. Reads take three edges (grant, issue, capture); a download
// takes the port over immediately and holds the CPUs in reset until HOLD
// cycles after it ends.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [16:0] BASE0    = 17'h00000,
  parameter logic [16:0] BASE1    = 17'h04000,
  parameter logic [16:0] BASE2    = 17'h05000,
  parameter logic [16:0] ROM_SIZE = 17'h06000,
  parameter int          HOLD     = HOLD_DEFAULT
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            dn_download,
  input  logic [16:0]     dn_addr,
  input  logic [7:0]      dn_data,
  input  logic            dn_wr,
  input  logic [NREQ-1:0] req,
  input  logic [15:0]     addr0,
  input  logic [15:0]     addr1,
  input  logic [15:0]     addr2,
  output logic [NREQ-1:0] ack,
  output logic [7:0]      rdata,
  output logic [16:0]     rom_addr,
  output logic [7:0]      rom_din,
  output logic            rom_we,
  input  logic [7:0]      rom_dout,
  output logic            core_reset
);

  // The hold counter is loaded with HOLD-1 and counts down to zero.
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  arb_state_e        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [16:0]       rom_addr_q, rom_addr_d;
  logic [7:0]        rom_din_q, rom_din_d;
  logic              rom_we_q, rom_we_d;
  logic              core_reset_q, core_reset_d;

  logic [NREQ-1:0]   pick;
  logic [16:0]       grant_addr;

  rr_pick u_rr_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  // ROM byte address of the requester that would win this cycle.
  always_comb begin
    grant_addr = BASE0 + {1'b0, addr0};
    if (pick[1]) grant_addr = BASE1 + {1'b0, addr1};
    if (pick[2]) grant_addr = BASE2 + {1'b0, addr2};
  end

  // Next-state and registered-output logic; a rising download overrides
  // whatever access is in flight.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    rom_addr_d = rom_addr_q;
    rom_din_d  = rom_din_q;
    rom_we_d   = 1'b0;

    if (dn_download && state_q != DL) begin
      state_d = DL;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_d    = ISSUE;
            gnt_d      = pick;
            last_d     = onehot_to_idx(pick);
            rom_addr_d = grant_addr;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          state_d = IDLE;
          ack_d   = gnt_q;
          rdata_d = rom_dout;
        end
        DL: begin
          rom_we_d   = dn_wr & (dn_addr < ROM_SIZE);
          rom_addr_d = dn_addr;
          rom_din_d  = dn_data;
          if (!dn_download) begin
            state_d = POST;
            cnt_d   = CNT_W'(HOLD - 1);
          end
        end
        POST: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    core_reset_d = (state_d == DL) || (state_d == POST);
  end

  // State and output registers; reset lands in DL if a download is active.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= dn_download ? DL : IDLE;
      last_q       <= 2'd2;
      gnt_q        <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      rom_addr_q   <= '0;
      rom_din_q    <= '0;
      rom_we_q     <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      rom_addr_q   <= rom_addr_d;
      rom_din_q    <= rom_din_d;
      rom_we_q     <= rom_we_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign rom_addr   = rom_addr_q;
  assign rom_din    = rom_din_q;
  assign rom_we     = rom_we_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios for reset, round-robin
// order, download abort/write/hold behaviour, then randomized CPU traffic
// checked against a transaction-level model of the arbiter.
module tb_rom_port_arbiter;

  localparam logic [16:0] B0   = 17'h00000;
  localparam logic [16:0] B1   = 17'h04000;
  localparam logic [16:0] B2   = 17'h05000;
  localparam logic [16:0] RSZ  = 17'h06000;
  localparam int          HOLD = 16;

  logic        clk_sys;
  logic        reset;
  logic        dn_download;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [2:0]  req;
  logic [15:0] addr0, addr1, addr2;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [16:0] rom_addr;
  logic [7:0]  rom_din;
  logic        rom_we;
  logic [7:0]  rom_dout;
  logic        core_reset;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference image of what the ROM should hold, written by the bench only.
  logic [7:0] img [0:131071];
  // The ROM itself: written only through the arbiter's port.
  logic [7:0] rom_mem [0:131071];

  typedef struct {
    int         e;
    logic [2:0] who;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];

  rom_port_arbiter dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dn_download (dn_download),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wr       (dn_wr),
    .req         (req),
    .addr0       (addr0),
    .addr1       (addr1),
    .addr2       (addr2),
    .ack         (ack),
    .rdata       (rdata),
    .rom_addr    (rom_addr),
    .rom_din     (rom_din),
    .rom_we      (rom_we),
    .rom_dout    (rom_dout),
    .core_reset  (core_reset)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk_sys) begin
    if (rom_we) rom_mem[rom_addr] <= rom_din;
    rom_dout <= rom_mem[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic count_hold(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      if (!core_reset) break;
      n++;
    end
  endtask

  function automatic logic [16:0] base_of(input int i);
    case (i)
      0:       return B0;
      1:       return B1;
      default: return B2;
    endcase
  endfunction

  function automatic logic [15:0] rand_addr(input int i);
    case (i)
      0:       return 16'($urandom_range(0, 32'h5FFF));
      1:       return 16'($urandom_range(0, 32'h1FFF));
      default: return 16'($urandom_range(0, 32'h0FFF));
    endcase
  endfunction

  initial begin
    int          n;
    logic [2:0]  want3;
    logic [16:0] prev_a;
    logic [7:0]  prev_d, d;
    int          edge_n, free_at, last_m, w, ea_i;
    logic [16:0] ea;
    logic [2:0]  req_v, req_r;
    logic [15:0] a_v [3];
    logic [15:0] a_r [3];

    for (int i = 0; i < 131072; i++) img[i] = 8'h00;

    reset = 1'b1; dn_download = 1'b0; dn_addr = '0; dn_data = '0; dn_wr = 1'b0;
    req = 3'b000; addr0 = '0; addr1 = '0; addr2 = '0;

    // Reset values.
    repeat (3) @(negedge clk_sys);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_din", rom_din, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_core_reset", core_reset, 1);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("idle_core_reset", core_reset, 0);

    // All three requesting: grants 0,1,2,0, one ack every third cycle.
    req = 3'b111;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_sys);
      want3 = (c == 3) ? 3'b001 : (c == 6) ? 3'b010 : (c == 9) ? 3'b100 :
              (c == 12) ? 3'b001 : 3'b000;
      chk("rr_ack", ack, want3);
    end

    // Download rises while requester 2 is in ISSUE: access abandoned.
    req = 3'b100;
    @(negedge clk_sys);
    chk("abort_grant_ack", ack, 0);
    dn_download = 1'b1;
    @(negedge clk_sys);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_ack", ack, 0);
    req = 3'b111;
    repeat (4) begin
      @(negedge clk_sys);
      chk("dl_req_ignored", {ack, rom_we}, 0);
    end
    req = 3'b000;

    // Full ROM download plus one write just past the end.
    prev_a = '0; prev_d = '0;
    for (int a = 0; a <= 32'h6000; a++) begin
      @(negedge clk_sys);
      if (a > 0)
        chk("dl_write", {core_reset, rom_we, rom_addr, rom_din}, {1'b1, 1'b1, prev_a, prev_d});
      d = (a == 32'h4010) ? 8'hA5 : 8'($urandom);
      dn_wr = 1'b1; dn_addr = 17'(a); dn_data = d;
      if (17'(a) < RSZ) img[a] = d;
      prev_a = 17'(a); prev_d = d;
    end
    @(negedge clk_sys);
    chk("dl_out_of_range", {core_reset, rom_we}, 2'b10);
    dn_wr = 1'b0;
    @(negedge clk_sys);
    chk("dl_tail", {core_reset, rom_we}, 2'b10);
    dn_download = 1'b0;
    count_hold(n);
    chk("hold_len", n, HOLD);

    // First read after the hold: requester 1 at offset 0x10.
    req = 3'b010; addr1 = 16'h0010;
    @(negedge clk_sys);
    chk("rd1_rom_addr", rom_addr, 17'h04010);
    chk("rd1_ack_e1", ack, 0);
    @(negedge clk_sys);
    chk("rd1_ack_e2", ack, 0);
    @(negedge clk_sys);
    chk("rd1_ack_e3", ack, 3'b010);
    chk("rd1_rdata", rdata, 8'hA5);
    req = 3'b000;

    // Download pulses again at POST cycle 8: hold restarts from final fall.
    dn_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    dn_download = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      chk("post_early", core_reset, 1);
    end
    dn_download = 1'b1;
    repeat (2) begin
      @(negedge clk_sys);
      chk("repulse_core_reset", core_reset, 1);
    end
    dn_download = 1'b0;
    count_hold(n);
    chk("rehold_len", n, HOLD);

    // Reset in the middle of an access drops it.
    req = 3'b001; addr0 = 16'h0000;
    @(negedge clk_sys);
    reset = 1'b1; req = 3'b000;
    @(negedge clk_sys);
    chk("midrst_ack", ack, 0);
    chk("midrst_core_reset", core_reset, 1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      chk("midrst_no_ack", ack, 0);
    end

    // Random CPU traffic against a transaction-level model: the arbiter is
    // free to sample at free_at; a grant at edge e acks at e+2 and frees the
    // arbiter for sampling again at e+3.
    edge_n = 0; free_at = 1; last_m = 2;
    req_v = 3'b000; req_r = 3'b000;
    for (int i = 0; i < 3; i++) begin a_v[i] = '0; a_r[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_sys);
      edge_n++;
      if (edge_n >= free_at && req_r != 3'b000) begin
        w = -1;
        for (int k = 1; k <= 3; k++) begin
          ea_i = (last_m + k) % 3;
          if (w < 0 && req_r[ea_i]) w = ea_i;
        end
        ea = base_of(w) + {1'b0, a_r[w]};
        q.push_back('{edge_n + 2, 3'(1 << w), img[ea]});
        last_m = w; free_at = edge_n + 3;
      end
      want3 = 3'b000;
      if (q.size() > 0 && q[0].e == edge_n) begin
        want3 = q[0].who;
        chk("rand_rdata", rdata, q[0].data);
        void'(q.pop_front());
      end
      chk("rand_ack", ack, want3);
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 1) begin req_v[i] = 1'b1; a_v[i] = rand_addr(i); end
          else req_v[i] = 1'b0;
        end else if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) begin req_v[i] = 1'b1; a_v[i] = rand_addr(i); end
        end else if ($urandom_range(0, 31) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      req = req_v; addr0 = a_v[0]; addr1 = a_v[1]; addr2 = a_v[2];
      req_r = req_v;
      for (int i = 0; i < 3; i++) a_r[i] = a_v[i];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
